mcycle_control_unit: RTL and testbench
======================================

# mcycle_control_unit

Multi-cycle sequencer for the 16-bit TSC-ISA datapath. It decodes the latched instruction, steps one FSM state per clock, and drives the datapath's 16-bit `signal` control word. It stalls on memory accesses until the memory handshake completes, counts retired instructions, and parks on HLT. It sits between `cpu` top-level memory glue and `data_path`.

## Interface
Parameters:
- `NUM_INST_W`, 16, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `instruction`  in  16  current IR contents from `data_path`
- `bcond`  in  1  branch condition from ALU, valid in BR state
- `mem_ready`  in  1  memory access complete this cycle (fetch, load or store)
- `signal`  out  16  control word: [15:14] PCSource, [13] ALUOp, [12:11] ALUSrcB, [10] ALUSrcA, [9] RegWrite, [8:7] RegDst, [6] PCWriteCond, [5] PCWrite, [4] IorD, [3] MemRead, [2] MemWrite, [1] MemtoReg, [0] IRWrite
- `state`  out  4  current FSM state, for debug
- `inst_done`  out  1  one-cycle pulse on the last cycle of each instruction
- `num_inst`  out  NUM_INST_W  retired-instruction count
- `halted`  out  1  high once HLT retires

## Operation
- Decode: opcode = `instruction`[15:12], func = [5:0] when opcode = 15.
- I-type opcodes: BNE 0, BEQ 1, BGZ 2, BLZ 3, ADI 4, ORI 5, LHI 6, LWD 7, SWD 8, JMP 9, JAL 10.
- R-type func codes: ADD 0 through SHR 7, JPR 25, JRL 26, WWD 28, HLT 29.
- `signal` is a Moore decode of state and opcode/func. Every field not listed for a state is 0.
- IF = 0x0009.
  - Stay in IF while `mem_ready` = 0.
  - Go to ID when `mem_ready` = 1.
- ID = 0x0820 (PC ← PC+1). Next state:
  - EX for R-ALU, ADI, ORI, LHI, LWD, SWD, WWD
  - BR for BNE/BEQ/BGZ/BLZ
  - JMP for JMP, JAL, JPR, JRL
  - HALT for HLT
  - IF for any other opcode/func, which is treated as NOP and retires.
- EX:
  - Values: R-ALU 0x2400, ADI/LHI/LWD/SWD 0x3400, ORI 0x3C00, WWD 0x0600.
  - Next state: WWD → IF and retires; LWD → MRD; SWD → MWR; otherwise → WB.
- MRD = 0x0018. Hold until `mem_ready` = 1, then → WB.
- MWR = 0x0014. Hold until `mem_ready` = 1, then → IF and retires.
- WB: R-ALU 0x0280, ADI/ORI/LHI 0x0200, LWD 0x0202. → IF and retires.
- BR = 0x4440. → IF and retires; the PC updates only if `bcond` is high.
- JMP: JMP 0x8020, JAL 0x8320, JPR 0x0420, JRL 0x0720. → IF and retires.
- HALT = 0x0000.
  - Absorbing: leave only via `reset`.
  - `halted` = 1 from the first HALT cycle onward.
  - The HLT instruction counts as retired: `num_inst` increments on ID→HALT.
- `inst_done` is high in the final state of each instruction (the cycle before returning to IF, or the ID→HALT cycle). `num_inst` increments on that same edge and wraps from 0xFFFF to 0x0000.

## Timing
- Reset (async, asserted): state = IF, `num_inst` = 0, `halted` = 0, `inst_done` = 0. `signal` is forced to 0x0000 combinationally while `reset` is high.
- First IF control word appears in the cycle after `reset` deasserts.
- Reset mid-instruction: abandon immediately; no partial retire, no counter increment.
- Minimum cycles, with `mem_ready` tied high:
  - R-ALU/ADI/ORI/LHI: 4
  - LWD: 5
  - SWD: 4
  - WWD, branch, jump: 3
  - HLT: 2 to HALT
- Each cycle of `mem_ready` = 0 in IF, MRD or MWR adds exactly one cycle. `signal` stays stable during the stall.
- `mem_ready` outside IF, MRD and MWR is ignored.
- `bcond` is sampled only in BR.
- `instruction` is sampled only in ID and later states. Changes during IF are ignored until the IF→ID edge.

## Test plan
- Reset then ADD (0xF1C0), `mem_ready` = 1: states IF, ID, EX, WB, then IF. `signal` sequence 0x0009, 0x0820, 0x2400, 0x0280. `inst_done` pulses once; `num_inst` = 1.
- LWD (0x7104) with `mem_ready` low for 2 cycles in IF and 3 in MRD: 10 cycles total. MRD drives 0x0018 for 4 cycles. WB = 0x0202.
- BEQ (0x1402) with `bcond` = 0, then again with `bcond` = 1: both take 3 cycles with BR = 0x4440. `num_inst` advances by 2.
- JAL (0xA123) → 0x8320; JPR (0xF019) → 0x0420; WWD (0xF01C) → EX 0x0600, then IF.
- HLT (0xF01D): `halted` = 1, `signal` = 0x0000 and stays in HALT for 20 cycles. Then `reset` pulses mid-cycle: `halted` = 0 immediately, `num_inst` = 0.
- Preload `num_inst` to 0xFFFF by retiring 65535 NOPs (opcode 11), then retire one more: `num_inst` = 0x0000 and `inst_done` still pulses.

Source files
------------

// File: rtl/mcycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit TSC-ISA datapath. It steps one state per clock,
// stalls on memory handshakes, counts retired instructions and parks on HLT.
// state | meaning: IF fetch | ID decode, PC+1 | EX execute | MRD/MWR memory read/write
//                  WB write back | BR branch | JMP jump/link | HALT parked until reset
module mcycle_control_unit #(
  parameter int NUM_INST_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           instruction,
  input  logic                  bcond,
  input  logic                  mem_ready,
  output logic [15:0]           signal,
  output logic [3:0]            state,
  output logic                  inst_done,
  output logic [NUM_INST_W-1:0] num_inst,
  output logic                  halted
);
  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MRD  = 4'd3,
    S_MWR  = 4'd4,
    S_WB   = 4'd5,
    S_BR   = 4'd6,
    S_JMP  = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_INST_W-1:0] num_inst_q;
  logic                  halted_q;
  logic                  retire_w;
  logic [15:0]           signal_w;

  logic [3:0] opcode_w;
  logic [5:0] func_w;
  logic is_rtype_w, is_ralu_w, is_adi_w, is_ori_w, is_lhi_w, is_lwd_w, is_swd_w;
  logic is_branch_w, is_jmp_w, is_jal_w, is_jpr_w, is_jrl_w, is_wwd_w, is_hlt_w;
  logic is_ex_w, is_jump_w;
  logic unused_w;

  assign opcode_w    = instruction[15:12];
  assign func_w      = instruction[5:0];
  assign is_rtype_w  = (opcode_w == 4'd15);
  assign is_ralu_w   = is_rtype_w && (func_w <= 6'd7);
  assign is_branch_w = (opcode_w <= 4'd3);
  assign is_adi_w    = (opcode_w == 4'd4);
  assign is_ori_w    = (opcode_w == 4'd5);
  assign is_lhi_w    = (opcode_w == 4'd6);
  assign is_lwd_w    = (opcode_w == 4'd7);
  assign is_swd_w    = (opcode_w == 4'd8);
  assign is_jmp_w    = (opcode_w == 4'd9);
  assign is_jal_w    = (opcode_w == 4'd10);
  assign is_jpr_w    = is_rtype_w && (func_w == 6'd25);
  assign is_jrl_w    = is_rtype_w && (func_w == 6'd26);
  assign is_wwd_w    = is_rtype_w && (func_w == 6'd28);
  assign is_hlt_w    = is_rtype_w && (func_w == 6'd29);
  assign is_ex_w     = is_ralu_w | is_adi_w | is_ori_w | is_lhi_w | is_lwd_w | is_swd_w | is_wwd_w;
  assign is_jump_w   = is_jmp_w | is_jal_w | is_jpr_w | is_jrl_w;

  // bcond gates the PC in the datapath through PCWriteCond; IR[11:6] only selects registers there.
  assign unused_w = ^{bcond, instruction[11:6]};

  always_comb begin
    state_d  = state_q;
    retire_w = 1'b0;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (is_hlt_w) begin
          state_d  = S_HALT;
          retire_w = 1'b1;
        end else if (is_branch_w) state_d = S_BR;
        else if (is_jump_w)       state_d = S_JMP;
        else if (is_ex_w)         state_d = S_EX;
        else begin
          state_d  = S_IF;
          retire_w = 1'b1;
        end
      end
      S_EX: begin
        if (is_wwd_w) begin
          state_d  = S_IF;
          retire_w = 1'b1;
        end else if (is_lwd_w) state_d = S_MRD;
        else if (is_swd_w)     state_d = S_MWR;
        else                   state_d = S_WB;
      end
      S_MRD: if (mem_ready) state_d = S_WB;
      S_MWR: if (mem_ready) begin
        state_d  = S_IF;
        retire_w = 1'b1;
      end
      S_WB, S_BR, S_JMP: begin
        state_d  = S_IF;
        retire_w = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    signal_w = 16'h0000;
    case (state_q)
      S_IF:  signal_w = 16'h0009;
      S_ID:  signal_w = 16'h0820;
      S_EX: begin
        if (is_ralu_w)                                  signal_w = 16'h2400;
        else if (is_adi_w | is_lhi_w | is_lwd_w | is_swd_w) signal_w = 16'h3400;
        else if (is_ori_w)                              signal_w = 16'h3C00;
        else if (is_wwd_w)                              signal_w = 16'h0600;
      end
      S_MRD: signal_w = 16'h0018;
      S_MWR: signal_w = 16'h0014;
      S_WB: begin
        if (is_ralu_w)                         signal_w = 16'h0280;
        else if (is_adi_w | is_ori_w | is_lhi_w) signal_w = 16'h0200;
        else if (is_lwd_w)                     signal_w = 16'h0202;
      end
      S_BR:  signal_w = 16'h4440;
      S_JMP: begin
        if (is_jmp_w)      signal_w = 16'h8020;
        else if (is_jal_w) signal_w = 16'h8320;
        else if (is_jpr_w) signal_w = 16'h0420;
        else if (is_jrl_w) signal_w = 16'h0720;
      end
      default: signal_w = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      num_inst_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire_w) num_inst_q <= num_inst_q + NUM_INST_W'(1);
      if (state_d == S_HALT) halted_q <= 1'b1;
    end
  end

  assign signal    = reset ? 16'h0000 : signal_w;
  assign inst_done = retire_w & ~reset;
  assign state     = state_q;
  assign num_inst  = num_inst_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_mcycle_control_unit.sv
// Scoreboard bench: stimulus tasks push per-cycle expectations built from the ISA timing
// rules; a monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_mcycle_control_unit;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   instruction;
  logic          bcond;
  logic          mem_ready;
  logic [15:0]   signal;
  logic [3:0]    dbg_state;
  logic          inst_done;
  logic [CW-1:0] num_inst;
  logic          halted;

  always #5 clk = ~clk;

  mcycle_control_unit #(.NUM_INST_W(CW)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .bcond(bcond),
    .mem_ready(mem_ready), .signal(signal), .state(dbg_state),
    .inst_done(inst_done), .num_inst(num_inst), .halted(halted)
  );

  typedef struct packed {
    logic [15:0]   sig;
    logic          done;
    logic [CW-1:0] cnt;
    logic          hlt;
  } exp_t;

  typedef enum int {K_NOP, K_RALU, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_WWD,
                    K_BR, K_JMP, K_JAL, K_JPR, K_JRL, K_HLT} kind_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_cnt;
  logic          m_hlt;

  function automatic kind_t kind_of(input logic [15:0] ins);
    kind_t k;
    int op, fn;
    op = int'(ins[15:12]);
    fn = int'(ins[5:0]);
    k = K_NOP;
    if (op <= 3) k = K_BR;
    else if (op == 4) k = K_ADI;
    else if (op == 5) k = K_ORI;
    else if (op == 6) k = K_LHI;
    else if (op == 7) k = K_LWD;
    else if (op == 8) k = K_SWD;
    else if (op == 9) k = K_JMP;
    else if (op == 10) k = K_JAL;
    else if (op == 15) begin
      if (fn <= 7) k = K_RALU;
      else if (fn == 25) k = K_JPR;
      else if (fn == 26) k = K_JRL;
      else if (fn == 28) k = K_WWD;
      else if (fn == 29) k = K_HLT;
    end
    return k;
  endfunction

  function automatic logic [15:0] rand_inst();
    logic [15:0] ins;
    int r;
    ins = 16'($urandom);
    r = int'($urandom_range(0, 17));
    if (r <= 10) ins[15:12] = 4'(r);
    else begin
      ins[15:12] = 4'hF;
      case (r)
        12: ins[5:0] = 6'd25;
        13: ins[5:0] = 6'd26;
        14: ins[5:0] = 6'd28;
        15: ins[15:12] = 4'(11 + $urandom_range(0, 3));
        16: ins[5:0] = 6'($urandom_range(8, 24));
        default: ins[5:0] = 6'($urandom_range(0, 7));
      endcase
    end
    return ins;
  endfunction

  // mr < 0 drives a random mem_ready where the sequencer must ignore it.
  task automatic step(input logic [15:0] sig, input logic done, input int mr, input logic [15:0] ins);
    exp_t e;
    instruction = ins;
    mem_ready   = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    bcond       = 1'($urandom_range(0, 1));
    e.sig  = sig;
    e.done = done;
    e.cnt  = m_cnt;
    e.hlt  = m_hlt;
    exp_q.push_back(e);
    if (done) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    reset       = 1'b1;
    mem_ready   = 1'($urandom_range(0, 1));
    instruction = 16'($urandom);
    m_cnt = '0;
    m_hlt = 1'b0;
    e.sig  = 16'h0000;
    e.done = 1'b0;
    e.cnt  = '0;
    e.hlt  = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_inst(input logic [15:0] ins, input int sif, input int smem);
    kind_t k;
    k = kind_of(ins);
    for (int i = 0; i < sif; i++) step(16'h0009, 1'b0, 0, 16'($urandom));
    step(16'h0009, 1'b0, 1, 16'($urandom));
    step(16'h0820, (k == K_NOP) || (k == K_HLT), -1, ins);
    case (k)
      K_HLT:  m_hlt = 1'b1;
      K_RALU: begin step(16'h2400, 1'b0, -1, ins); step(16'h0280, 1'b1, -1, ins); end
      K_ADI, K_LHI: begin step(16'h3400, 1'b0, -1, ins); step(16'h0200, 1'b1, -1, ins); end
      K_ORI:  begin step(16'h3C00, 1'b0, -1, ins); step(16'h0200, 1'b1, -1, ins); end
      K_LWD: begin
        step(16'h3400, 1'b0, -1, ins);
        for (int i = 0; i < smem; i++) step(16'h0018, 1'b0, 0, ins);
        step(16'h0018, 1'b0, 1, ins);
        step(16'h0202, 1'b1, -1, ins);
      end
      K_SWD: begin
        step(16'h3400, 1'b0, -1, ins);
        for (int i = 0; i < smem; i++) step(16'h0014, 1'b0, 0, ins);
        step(16'h0014, 1'b1, 1, ins);
      end
      K_WWD: step(16'h0600, 1'b1, -1, ins);
      K_BR:  step(16'h4440, 1'b1, -1, ins);
      K_JMP: step(16'h8020, 1'b1, -1, ins);
      K_JAL: step(16'h8320, 1'b1, -1, ins);
      K_JPR: step(16'h0420, 1'b1, -1, ins);
      K_JRL: step(16'h0720, 1'b1, -1, ins);
      default: ;
    endcase
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({signal, inst_done, num_inst, halted} !== e) begin
          errors++;
          $display("FAIL cycle_chk t=%0t state=%0d: got sig=%h done=%b cnt=%h hlt=%b, expected sig=%h done=%b cnt=%h hlt=%b",
                   $time, dbg_state, signal, inst_done, num_inst, halted, e.sig, e.done, e.cnt, e.hlt);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL watchdog: stimulus did not complete within the time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    logic [15:0] nop;
    reset = 1'b1;
    mem_ready = 1'b0;
    bcond = 1'b0;
    instruction = 16'h0000;
    m_cnt = '0;
    m_hlt = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_inst(16'hF1C0, 0, 0);
    run_inst(16'h7104, 2, 3);
    run_inst(16'h1402, 0, 0);
    run_inst(16'h1402, 0, 0);
    run_inst(16'hA123, 0, 0);
    run_inst(16'hF019, 0, 0);
    run_inst(16'hF01C, 0, 0);

    for (int n = 0; n < 300; n++)
      run_inst(rand_inst(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Abandon an ADD in EX: nothing may retire.
    step(16'h0009, 1'b0, 1, 16'($urandom));
    step(16'h0820, 1'b0, -1, 16'hF1C0);
    step(16'h2400, 1'b0, -1, 16'hF1C0);
    do_reset();
    run_inst(16'hF1C0, 0, 0);

    do_reset();
    for (int n = 0; n < (1 << CW); n++) begin
      nop = 16'($urandom);
      nop[15:12] = 4'(11 + $urandom_range(0, 3));
      run_inst(nop, 0, 0);
    end
    run_inst(16'h5ABC, 1, 0);

    run_inst(16'hF01D, 0, 0);
    for (int n = 0; n < 20; n++) step(16'h0000, 1'b0, -1, 16'($urandom));
    do_reset();
    run_inst(16'hF1C0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
